// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit controller: FSM encoding,
// parity type constants and the default frame data width.
package uart_tx_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Bit counter width; a one-bit frame still needs a one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_shift.sv
// Active-frame datapath: data shift register, bit counter and parity
// generator. bit_out is the bit the line should carry after the next edge.
module uart_tx_shift
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  bit_out,
  output logic                  par_bit,
  output logic                  last_bit
);

  localparam int unsigned CNT_W    = cnt_width(DATA_WIDTH);
  localparam int unsigned LAST_IDX = DATA_WIDTH - 1;

  logic [DATA_WIDTH-1:0] sr_q;
  logic [DATA_WIDTH-1:0] sr_d;
  logic [CNT_W-1:0]      cnt_q;
  logic                  par_q;

  assign sr_d = sr_q >> 1;

  // Parity is taken once from the captured word so later shifting cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
      par_q <= 1'b0;
    end else if (load) begin
      sr_q  <= data_in;
      cnt_q <= '0;
      par_q <= ^data_in;
    end else if (shift) begin
      sr_q  <= sr_d;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bit_out  = shift ? sr_d[0] : sr_q[0];
  assign par_bit  = par_q;
  assign last_bit = (cnt_q == CNT_W'(LAST_IDX));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: one-entry pending buffer in front of the active frame,
// frame sequencing FSM and registered serial line driver.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  DATA_READY,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  FRAME_DONE
);

  tx_state_e state_q;
  logic      tx_q;
  logic      busy_q;
  logic      done_q;
  logic      rdy_q;

  logic [DATA_WIDTH-1:0] pend_data_q;
  logic                  pend_par_en_q;
  logic                  pend_par_typ_q;
  logic                  fr_par_en_q;
  logic                  fr_par_typ_q;

  logic                  accept;
  logic                  in_frame;
  logic                  take_pend;
  logic                  to_pend;
  logic                  load;
  logic                  shift;
  logic [DATA_WIDTH-1:0] load_data_d;
  logic                  load_par_en_d;
  logic                  load_par_typ_d;
  logic                  bit_out;
  logic                  par_bit;
  logic                  last_bit;
  logic                  par_line;

  assign accept    = DATA_VALID & rdy_q;
  assign in_frame  = (state_q == START) | (state_q == DATA) | (state_q == PARITY);
  assign take_pend = (state_q == STOP) & ~rdy_q;
  assign to_pend   = accept & in_frame;
  assign load      = take_pend | (accept & ((state_q == IDLE) | (state_q == STOP)));
  assign shift     = (state_q == DATA) & ~last_bit;

  // A buffered word always wins the shift register over the input port.
  assign load_data_d    = take_pend ? pend_data_q    : P_DATA;
  assign load_par_en_d  = take_pend ? pend_par_en_q  : PAR_EN;
  assign load_par_typ_d = take_pend ? pend_par_typ_q : PAR_TYP;

  assign par_line = (fr_par_typ_q == PAR_EVEN) ? par_bit : ~par_bit;

  uart_tx_shift #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shift (
    .clk      (CLK),
    .rst      (RST),
    .load     (load),
    .shift    (shift),
    .data_in  (load_data_d),
    .bit_out  (bit_out),
    .par_bit  (par_bit),
    .last_bit (last_bit)
  );

  // Pending buffer and the parity settings of the frame on the line.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rdy_q          <= 1'b1;
      pend_data_q    <= '0;
      pend_par_en_q  <= 1'b0;
      pend_par_typ_q <= 1'b0;
      fr_par_en_q    <= 1'b0;
      fr_par_typ_q   <= 1'b0;
    end else begin
      if (take_pend) begin
        rdy_q <= 1'b1;
      end else if (to_pend) begin
        rdy_q          <= 1'b0;
        pend_data_q    <= P_DATA;
        pend_par_en_q  <= PAR_EN;
        pend_par_typ_q <= PAR_TYP;
      end
      if (load) begin
        fr_par_en_q  <= load_par_en_d;
        fr_par_typ_q <= load_par_typ_d;
      end
    end
  end

  // Outputs are registered alongside the state they belong to.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            state_q <= START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          state_q <= DATA;
          tx_q    <= bit_out;
        end
        DATA: begin
          if (!last_bit) begin
            tx_q <= bit_out;
          end else if (fr_par_en_q) begin
            state_q <= PARITY;
            tx_q    <= par_line;
          end else begin
            state_q <= STOP;
            tx_q    <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        PARITY: begin
          state_q <= STOP;
          tx_q    <= 1'b1;
          done_q  <= 1'b1;
        end
        STOP: begin
          if (load) begin
            state_q <= START;
            tx_q    <= 1'b0;
          end else begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign DATA_READY = rdy_q;
  assign TX_OUT     = tx_q;
  assign Busy       = busy_q;
  assign FRAME_DONE = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: per-cycle line scoreboard plus
// table-driven frames and hand-written back-to-back / stop-cycle / reset cases.
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       DATA_READY;
  logic       TX_OUT;
  logic       Busy;
  logic       FRAME_DONE;

  int errs   = 0;
  int checks = 0;
  logic mon_en = 1'b0;

  typedef struct packed {
    logic busy;
    logic tx;
    logic done;
  } line_t;

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       ptyp;
    logic       exp_par;
    int         exp_len;
  } vec_t;

  line_t exp_q[$];
  vec_t  vecs[8];

  localparam line_t IDLE_LINE = '{busy: 1'b0, tx: 1'b1, done: 1'b0};

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .DATA_READY (DATA_READY),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy),
    .FRAME_DONE (FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Expected line activity for one frame: start, data LSB first, optional parity, stop.
  task automatic push_frame(input logic [7:0] d, input logic pen, input logic par);
    exp_q.push_back('{busy: 1'b1, tx: 1'b0, done: 1'b0});
    for (int i = 0; i < 8; i++) exp_q.push_back('{busy: 1'b1, tx: d[i], done: 1'b0});
    if (pen) exp_q.push_back('{busy: 1'b1, tx: par, done: 1'b0});
    exp_q.push_back('{busy: 1'b1, tx: 1'b1, done: 1'b1});
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Line monitor: every cycle must match the scoreboard head, or idle when it is empty.
  always @(negedge CLK) begin
    if (mon_en) begin
      line_t e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_LINE;
      chk("line{busy,tx,done}", 32'({Busy, TX_OUT, FRAME_DONE}), 32'(e));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 11};
    vecs[1] = '{8'h01, 1'b1, 1'b1, 1'b0, 11};
    vecs[2] = '{8'h03, 1'b1, 1'b1, 1'b1, 11};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b0, 10};
    vecs[4] = '{8'h00, 1'b1, 1'b0, 1'b0, 11};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 11};
    vecs[6] = '{8'h80, 1'b1, 1'b0, 1'b1, 11};
    vecs[7] = '{8'h7E, 1'b1, 1'b0, 1'b0, 11};

    RST = 1'b1;
    P_DATA = 8'h00;
    DATA_VALID = 1'b0;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("reset_ready", 32'(DATA_READY), 32'd1);
    chk("reset_tx", 32'(TX_OUT), 32'd1);
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_done", 32'(FRAME_DONE), 32'd0);
    #1 mon_en = 1'b1;

    // Table-driven single frames from idle, with parity settings disturbed mid-frame.
    for (int v = 0; v < 8; v++) begin
      next_cycle();
      P_DATA = vecs[v].data;
      PAR_EN = vecs[v].pen;
      PAR_TYP = vecs[v].ptyp;
      DATA_VALID = 1'b1;
      exp_q.push_back(IDLE_LINE);
      push_frame(vecs[v].data, vecs[v].pen, vecs[v].exp_par);
      cnt = 0;
      for (int c = 0; c < 14; c++) begin
        next_cycle();
        if (c == 0) begin
          DATA_VALID = 1'b0;
          PAR_EN = ~PAR_EN;
          PAR_TYP = ~PAR_TYP;
          P_DATA = 8'($urandom);
        end
        @(negedge CLK);
        if (Busy) cnt++;
      end
      chk($sformatf("frame_len_%0d", v), 32'(cnt), 32'(vecs[v].exp_len));
    end
    drain();

    // Back-to-back: second word buffered, third word refused while buffer full.
    next_cycle();
    P_DATA = 8'h55;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    DATA_VALID = 1'b1;
    exp_q.push_back(IDLE_LINE);
    push_frame(8'h55, 1'b0, 1'b0);
    for (int cyc = 1; cyc <= 11; cyc++) begin
      next_cycle();
      if (cyc == 1) begin
        P_DATA = 8'h0F;
        PAR_EN = 1'b1;
        PAR_TYP = 1'b1;
        DATA_VALID = 1'b1;
        push_frame(8'h0F, 1'b1, 1'b1);
      end else if (cyc >= 3 && cyc <= 5) begin
        P_DATA = 8'hAA;
        PAR_EN = 1'b0;
        DATA_VALID = 1'b1;
      end else begin
        DATA_VALID = 1'b0;
      end
      @(negedge CLK);
      chk($sformatf("b2b_ready_c%0d", cyc), 32'(DATA_READY),
          (cyc >= 2 && cyc <= 10) ? 32'd0 : 32'd1);
    end
    drain();
    repeat (5) next_cycle();

    // Word offered in the stop cycle itself starts the next frame with no gap.
    next_cycle();
    P_DATA = 8'h3C;
    PAR_EN = 1'b0;
    DATA_VALID = 1'b1;
    exp_q.push_back(IDLE_LINE);
    push_frame(8'h3C, 1'b0, 1'b0);
    next_cycle();
    DATA_VALID = 1'b0;
    repeat (9) next_cycle();
    P_DATA = 8'h96;
    PAR_EN = 1'b1;
    PAR_TYP = 1'b0;
    DATA_VALID = 1'b1;
    push_frame(8'h96, 1'b1, 1'b0);
    @(negedge CLK);
    chk("stop_cycle_done", 32'(FRAME_DONE), 32'd1);
    chk("stop_cycle_ready", 32'(DATA_READY), 32'd1);
    next_cycle();
    DATA_VALID = 1'b0;
    @(negedge CLK);
    chk("stop_next_start_tx", 32'(TX_OUT), 32'd0);
    chk("stop_next_start_busy", 32'(Busy), 32'd1);
    drain();
    repeat (3) next_cycle();

    // Reset on the 4th data bit; offered word in the reset cycle is dropped.
    next_cycle();
    P_DATA = 8'hC3;
    PAR_EN = 1'b1;
    PAR_TYP = 1'b0;
    DATA_VALID = 1'b1;
    exp_q.push_back(IDLE_LINE);
    push_frame(8'hC3, 1'b1, 1'b0);
    next_cycle();
    DATA_VALID = 1'b0;
    repeat (4) next_cycle();
    RST = 1'b1;
    P_DATA = 8'h5A;
    DATA_VALID = 1'b1;
    @(negedge CLK);
    chk("rst_bit3_tx", 32'(TX_OUT), 32'd0);
    next_cycle();
    RST = 1'b0;
    DATA_VALID = 1'b0;
    exp_q.delete();
    @(negedge CLK);
    chk("rst_tx", 32'(TX_OUT), 32'd1);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_ready", 32'(DATA_READY), 32'd1);
    chk("rst_done", 32'(FRAME_DONE), 32'd0);
    repeat (3) next_cycle();
    next_cycle();
    P_DATA = 8'h81;
    PAR_EN = 1'b1;
    PAR_TYP = 1'b1;
    DATA_VALID = 1'b1;
    exp_q.push_back(IDLE_LINE);
    push_frame(8'h81, 1'b1, 1'b1);
    next_cycle();
    DATA_VALID = 1'b0;
    drain();
    repeat (10) next_cycle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
